memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port RAM arbiter between the instruction fetch path (iREN) and the data path (dREN/dWEN, driven by the control unit's LW/SW decode). It grants one requester at a time and holds the grant until the RAM reports ACCESS. Data requests have priority, bounded by a starvation counter that forces an instruction grant. It sits between the datapath/caches and the RAM model.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before an instruction grant is forced (1..15).

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous reset, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address (word_t).
- iwait  out  1  high while the instruction request is not complete.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  high while the data request is not complete.
- dload  out  32  data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

## Operation
- FSM states: IDLE, IGRANT, DGRANT. Reset to IDLE; starvation count 0.
- IDLE: drives no RAM strobes. Next state: DGRANT if (dREN|dWEN) and count < STARVE_MAX; else IGRANT if iREN; else IDLE. If dREN|dWEN and iREN are both pending and count == STARVE_MAX, go to IGRANT.
- IGRANT: ramREN=1, ramaddr=iaddr. On ramstate==ACCESS, iwait=0 and iload=ramload in that cycle, count clears to 0, and the FSM returns to IDLE.
- DGRANT: ramaddr=daddr, ramstore=dstore. dWEN has priority over dREN when both are high, giving ramWEN=1 and ramREN=0. On ACCESS, dwait=0 and dload=ramload in that cycle, and the FSM returns to IDLE. At completion, count increments (saturating at STARVE_MAX) if iREN is high, and clears otherwise.
- Request withdrawn mid-grant (the granted enable falls before ACCESS): strobes drop the same cycle and the FSM returns to IDLE. The count is unchanged.
- ramstate BUSY, FREE or ERROR during a grant: hold the grant and keep the wait high. ERROR is not retried or flagged here.
- iwait = iREN & ~(state==IGRANT & ACCESS). dwait = (dREN|dWEN) & ~(state==DGRANT & ACCESS). Both waits are 0 when there is no request.
- iload and dload are pass-throughs of ramload (unqualified). Consumers sample only when the wait is low.

## Timing
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=iREN, dwait=dREN|dWEN. State is IDLE.
- Reset mid-grant: strobes go to 0 asynchronously, with no partial completion.
- Minimum latency: request at cycle 0 (IDLE), strobe at cycle 1, wait low at cycle 1 if ACCESS arrives then, IDLE at cycle 2.
- There is always one IDLE arbitration cycle between grants, so back-to-back accesses cost at least 2 cycles each.
- Requesters hold enable, address and store data stable until their wait goes low. The arbiter does not latch them.
- RAM outputs are combinational from state and inputs. The only registers are state and the count.

## Structure
- cpu_types_pkg: ramstate_t (existing), word_t, and a new arb_state_t enum (IDLE, IGRANT, DGRANT).
- Sub-module: starve_counter, a 4-bit saturating counter with clear, increment and saturate-at-STARVE_MAX. It is instantiated once.
- Output mux and FSM stay in memory_arbiter.

## Test plan
- Lone iREN, iaddr=0x40, RAM ACCESS on first strobe cycle, ramload=0x8C220004 -> ramREN high cycle 1, iwait low cycle 1, iload=0x8C220004.
- iREN and dREN both high, daddr=0x100, RAM takes 3 BUSY cycles then ACCESS -> DGRANT first, dwait low on cycle 4, IGRANT at cycle 6.
- dREN and dWEN both high, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- STARVE_MAX=4, iREN held, five back-to-back data requests -> four DGRANTs, then IGRANT, then the fifth DGRANT; count is 0 after the IGRANT.
- dREN dropped at cycle 2 of a BUSY grant -> ramREN low the same cycle, IDLE next cycle, pending iREN granted after that.
- nRST asserted during IGRANT with BUSY -> ramREN=0 immediately, IDLE. After release, the held iREN is re-granted after one IDLE cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, machine word, arbiter FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    // Machine word used for addresses and data on both sides of the arbiter.
    typedef logic [31:0] word_t;

    // RAM model handshake state; ACCESS marks the cycle the request completes.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership of the single RAM port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // Width of the starvation counter; STARVE_MAX must fit (1..15).
    localparam int CNT_W = 4;

    // A data-side request is pending when either the load or the store enable is up.
    function automatic logic data_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of data grants completed while an instruction fetch waits.
// Latency: updates on the clock edge after clr/inc; clr wins over inc.
// Backpressure: none; holds at STARVE_MAX until cleared.
module starve_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic sat;

    // Saturation flag stops the increment at the configured ceiling.
    always_comb begin
        sat = (count == MAX_CNT);
    end

    // Count register: clear has priority, increment only below the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data path has priority, instruction fetch forced after STARVE_MAX data grants.
// Latency: one IDLE arbitration cycle, then strobe; completion in the cycle the RAM reports ACCESS.
// Backpressure: iwait/dwait stay high until ACCESS in the owner's grant; requesters hold their inputs stable.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             dreq;
    logic             i_done;
    logic             d_done;
    logic             data_allowed;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (CLK),
        .rst   (nRST),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (starve_cnt)
    );

    // Data wins arbitration unless a waiting fetch has already been passed over STARVE_MAX times.
    always_comb begin
        dreq         = data_req(dREN, dWEN);
        data_allowed = (starve_cnt < MAX_CNT) || !iREN;
    end

    // Grant register; async reset drops any grant with no partial completion.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration, RAM strobe/address mux and completion detection.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && data_allowed) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    // Fetch withdrawn: release the port, starvation history untouched.
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        i_done     = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DGRANT: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    // A store beats a load if the control unit raises both.
                    ramWEN   = dWEN;
                    ramREN   = !dWEN;
                    if (ramstate == ACCESS) begin
                        d_done     = 1'b1;
                        next_state = IDLE;
                        if (iREN) begin
                            cnt_inc = 1'b1;
                        end else begin
                            cnt_clr = 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Waits track the raw requests; load data is an unqualified pass-through of the RAM.
    always_comb begin
        iwait = iREN & ~i_done;
        dwait = dreq & ~d_done;
        iload = ramload;
        dload = ramload;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic against a transaction-level model.
// Latency: checks are sampled 2 time units after each rising edge.
// Backpressure: bench requesters hold enables/address/data until the expected wait goes low.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int SMAX = 4;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model of who holds the RAM port (0 none, 1 fetch, 2 data) and fetch-starvation tally.
    int    m_owner;
    int    m_tally;
    int    glog[$];
    int    exp_seq[10];
    int    r;
    logic  dq, i_fin, d_fin, e_ren, e_wen;
    logic  n_iren, n_dren, n_dwen;
    word_t n_iaddr, n_daddr, n_dstore;
    logic  adv_i, adv_d;

    initial begin
        exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        // ---------------- reset state ----------------
        nRST = 1'b1; iREN = 1'b1; iaddr = '0; dREN = 1'b1; dWEN = 1'b0;
        daddr = '0; dstore = 32'h1234_5678; ramload = '0; ramstate = FREE;
        #2;
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk32("rst_ramaddr", ramaddr, 32'h0);
        chk32("rst_ramstore", ramstore, 32'h0);
        chk1("rst_iwait_req", iwait, 1'b1);
        chk1("rst_dwait_req", dwait, 1'b1);
        iREN = 1'b0; dREN = 1'b0;
        #1;
        chk1("rst_iwait_noreq", iwait, 1'b0);
        chk1("rst_dwait_noreq", dwait, 1'b0);
        step();
        nRST = 1'b0;

        // ---------------- lone fetch, ACCESS on first strobe ----------------
        iREN = 1'b1; iaddr = 32'h40;
        #1;
        chk1("t1_c0_ramREN", ramREN, 1'b0);
        chk1("t1_c0_iwait", iwait, 1'b1);
        step();
        ramstate = ACCESS; ramload = 32'h8C22_0004;
        #1;
        chk1("t1_c1_ramREN", ramREN, 1'b1);
        chk32("t1_c1_ramaddr", ramaddr, 32'h40);
        chk1("t1_c1_iwait", iwait, 1'b0);
        chk32("t1_c1_iload", iload, 32'h8C22_0004);
        step();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk1("t1_c2_ramREN", ramREN, 1'b0);

        // ---------------- fetch + load together, load wins, 3 BUSY ----------------
        step();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
        #1;
        chk1("t2_c0_ramREN", ramREN, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            #1;
            chk1("t2_busy_ramREN", ramREN, 1'b1);
            chk32("t2_busy_ramaddr", ramaddr, 32'h100);
            chk1("t2_busy_dwait", dwait, 1'b1);
            chk1("t2_busy_iwait", iwait, 1'b1);
        end
        step();
        ramstate = ACCESS; ramload = 32'hCAFE_0001;
        #1;
        chk1("t2_c4_dwait", dwait, 1'b0);
        chk32("t2_c4_dload", dload, 32'hCAFE_0001);
        step();
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk1("t2_c5_idle", ramREN, 1'b0);
        step();
        ramstate = ACCESS;
        #1;
        chk1("t2_c6_ramREN", ramREN, 1'b1);
        chk32("t2_c6_ramaddr", ramaddr, 32'h44);
        chk1("t2_c6_iwait", iwait, 1'b0);
        step();
        iREN = 1'b0; ramstate = FREE;

        // ---------------- load+store together: store wins ----------------
        step();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        step();
        ramstate = ACCESS;
        #1;
        chk1("t3_ramWEN", ramWEN, 1'b1);
        chk1("t3_ramREN", ramREN, 1'b0);
        chk32("t3_ramstore", ramstore, 32'hDEAD_BEEF);
        chk32("t3_ramaddr", ramaddr, 32'h200);
        chk1("t3_dwait", dwait, 1'b0);
        step();
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        step();

        // ---------------- starvation: fetch forced after SMAX data grants ----------------
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h1000; ramstate = ACCESS;
        for (int c = 0; c < 30 && glog.size() < 10; c++) begin
            #1;
            if (ramREN || ramWEN) glog.push_back((ramaddr < 32'h1000) ? 1 : 2);
            adv_i = !iwait;
            adv_d = !dwait;
            step();
            if (adv_i) iaddr = iaddr + 32'd4;
            if (adv_d) daddr = daddr + 32'd4;
        end
        chk32("t4_ngrants", 32'(glog.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk32("t4_grant_seq", 32'((k < glog.size()) ? glog[k] : 0), 32'(exp_seq[k]));
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        step();

        // ---------------- load withdrawn mid-grant ----------------
        dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h90; ramstate = BUSY;
        #1;
        chk1("t5_c0_ramREN", ramREN, 1'b0);
        step();
        #1;
        chk1("t5_c1_ramREN", ramREN, 1'b1);
        chk32("t5_c1_ramaddr", ramaddr, 32'h300);
        step();
        dREN = 1'b0;
        #1;
        chk1("t5_c2_ramREN_drop", ramREN, 1'b0);
        chk1("t5_c2_dwait", dwait, 1'b0);
        chk1("t5_c2_iwait", iwait, 1'b1);
        step();
        #1;
        chk1("t5_c3_idle", ramREN, 1'b0);
        step();
        ramstate = ACCESS;
        #1;
        chk1("t5_c4_ramREN", ramREN, 1'b1);
        chk32("t5_c4_ramaddr", ramaddr, 32'h90);
        chk1("t5_c4_iwait", iwait, 1'b0);
        step();
        iREN = 1'b0; ramstate = FREE;

        // ---------------- reset during a BUSY fetch grant ----------------
        step();
        iREN = 1'b1; iaddr = 32'hA0; ramstate = BUSY;
        step();
        #1;
        chk1("t6_grant_ramREN", ramREN, 1'b1);
        #1;
        nRST = 1'b1;
        #1;
        chk1("t6_rst_ramREN", ramREN, 1'b0);
        chk32("t6_rst_ramaddr", ramaddr, 32'h0);
        chk1("t6_rst_iwait", iwait, 1'b1);
        step();
        nRST = 1'b0;
        #1;
        chk1("t6_idle_ramREN", ramREN, 1'b0);
        step();
        ramstate = ACCESS;
        #1;
        chk1("t6_regrant_ramREN", ramREN, 1'b1);
        chk32("t6_regrant_ramaddr", ramaddr, 32'hA0);
        chk1("t6_regrant_iwait", iwait, 1'b0);
        step();
        iREN = 1'b0; ramstate = FREE;
        step();

        // ---------------- randomized traffic vs transaction-level model ----------------
        m_owner = 0;
        m_tally = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = int'($urandom % 6);
            case (r)
                0, 1:    ramstate = ACCESS;
                2, 5:    ramstate = BUSY;
                3:       ramstate = FREE;
                default: ramstate = ERROR;
            endcase
            ramload = $urandom;
            #1;
            dq    = dREN | dWEN;
            i_fin = (m_owner == 1) && iREN && (ramstate == ACCESS);
            d_fin = (m_owner == 2) && dq && (ramstate == ACCESS);
            e_ren = ((m_owner == 1) && iREN) || ((m_owner == 2) && dREN && !dWEN);
            e_wen = (m_owner == 2) && dWEN;
            chk1("rnd_ramREN", ramREN, e_ren);
            chk1("rnd_ramWEN", ramWEN, e_wen);
            chk1("rnd_iwait", iwait, iREN && !i_fin);
            chk1("rnd_dwait", dwait, dq && !d_fin);
            chk32("rnd_iload", iload, ramload);
            chk32("rnd_dload", dload, ramload);
            if (m_owner == 1 && iREN) chk32("rnd_ramaddr_i", ramaddr, iaddr);
            if (m_owner == 2 && dq) begin
                chk32("rnd_ramaddr_d", ramaddr, daddr);
                chk32("rnd_ramstore", ramstore, dstore);
            end

            // Ownership moves: completion or withdrawal frees the port; arbitration from a free port.
            if (m_owner == 0) begin
                if (dq && (m_tally < SMAX || !iREN)) m_owner = 2;
                else if (iREN)                       m_owner = 1;
            end else if (m_owner == 1) begin
                if (i_fin) m_tally = 0;
                if (i_fin || !iREN) m_owner = 0;
            end else begin
                if (d_fin) m_tally = iREN ? ((m_tally < SMAX) ? m_tally + 1 : SMAX) : 0;
                if (d_fin || !dq) m_owner = 0;
            end

            // Requesters: start, hold, finish or occasionally abandon a request.
            n_iren = iREN; n_iaddr = iaddr;
            n_dren = dREN; n_dwen = dWEN; n_daddr = daddr; n_dstore = dstore;
            if (iREN && !i_fin) begin
                if ($urandom % 20 == 0) n_iren = 1'b0;
            end else begin
                n_iren  = ($urandom % 2 == 0);
                n_iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (dq && !d_fin) begin
                if ($urandom % 20 == 0) begin n_dren = 1'b0; n_dwen = 1'b0; end
            end else begin
                r = int'($urandom % 5);
                n_dren   = (r == 1) || (r == 3);
                n_dwen   = (r == 2) || (r == 3);
                n_daddr  = $urandom & 32'hFFFF_FFFC;
                n_dstore = $urandom;
            end
            step();
            iREN = n_iren; iaddr = n_iaddr;
            dREN = n_dren; dWEN = n_dwen; daddr = n_daddr; dstore = n_dstore;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
